// File: rtl/motor_pkg.sv
// Shared types and constants for the motor commutation blocks.
package motor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_RAMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_BRAKE = 3'd4
  } state_t;

  localparam logic [2:0] MAX_STEP = 3'd5;

  // Steps 6 and 7 do not exist in the six-step pattern; fall back to step 0.
  function automatic logic [2:0] sanitize_step(input logic [2:0] step);
    return (step > MAX_STEP) ? 3'd0 : step;
  endfunction

endpackage

// File: rtl/period_timer.sv
// Loadable down-counter; o_tc flags the last cycle of the loaded interval.
module period_timer #(
  parameter int K_PERIOD_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic [K_PERIOD_W-1:0] i_val,
  output logic                  o_tc
);

  logic [K_PERIOD_W-1:0] cnt;

  // A load value of 0 behaves as 1 so the interval is never empty.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= (i_val == '0) ? K_PERIOD_W'(1) : i_val;
    end else if (i_en && cnt > K_PERIOD_W'(1)) begin
      cnt <= cnt - K_PERIOD_W'(1);
    end
  end

  assign o_tc = i_en && (cnt <= K_PERIOD_W'(1));

endmodule

// File: rtl/commutation_sequencer.sv
// Open-loop start-up sequencer: align, accelerating ramp, steady run and timed brake.
module commutation_sequencer
  import motor_pkg::*;
#(
  parameter int K_NSUBSTEPS = 10,
  parameter int K_PERIOD_W  = 16,
  localparam int PW = $clog2(K_NSUBSTEPS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_brake_req,
  input  logic                  i_dir,
  input  logic [2:0]            i_align_step,
  input  logic [K_PERIOD_W-1:0] i_align_cycles,
  input  logic [PW-1:0]         i_align_power,
  input  logic [PW-1:0]         i_run_power,
  input  logic [K_PERIOD_W-1:0] i_start_period,
  input  logic [K_PERIOD_W-1:0] i_run_period,
  input  logic [K_PERIOD_W-1:0] i_ramp_dec,
  input  logic [K_PERIOD_W-1:0] i_brake_cycles,
  output logic                  o_step_trigger,
  output logic                  o_force_step_trigger,
  output logic [2:0]            o_force_step_value,
  output logic [PW-1:0]         o_force_substep,
  output logic                  o_step_reverse,
  output logic                  o_brake,
  output logic [PW-1:0]         o_power,
  output logic [2:0]            o_state,
  output logic                  o_running
);

  localparam logic [PW-1:0] SUB_LAST = PW'(K_NSUBSTEPS - 1);

  function automatic logic [K_PERIOD_W-1:0] sat_sub(input logic [K_PERIOD_W-1:0] a,
                                                     input logic [K_PERIOD_W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  function automatic logic [K_PERIOD_W-1:0] max_p(input logic [K_PERIOD_W-1:0] a,
                                                   input logic [K_PERIOD_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t                state, state_n;
  logic [PW-1:0]         sub_cnt, sub_n;
  logic [K_PERIOD_W-1:0] cur_period, period_n, period_next, ramp_start;
  logic                  tmr_en, tmr_load, tmr_tc, trig_n, stop_req;
  logic [K_PERIOD_W-1:0] tmr_val;

  assign stop_req    = i_brake_req || !i_enable;
  assign ramp_start  = max_p(i_start_period, i_run_period);
  assign period_next = max_p(sat_sub(cur_period, i_ramp_dec), i_run_period);
  assign tmr_en      = (state != ST_IDLE);

  period_timer #(.K_PERIOD_W(K_PERIOD_W)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (tmr_en),
    .i_load  (tmr_load),
    .i_val   (tmr_val),
    .o_tc    (tmr_tc)
  );

  // The timer is reloaded on the same edge as each transition or pulse, so
  // intervals chain back to back without a gap cycle.
  always_comb begin
    state_n  = state;
    sub_n    = sub_cnt;
    period_n = cur_period;
    tmr_load = 1'b0;
    tmr_val  = i_run_period;
    trig_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_enable && !i_brake_req) begin
          state_n  = ST_ALIGN;
          tmr_load = 1'b1;
          tmr_val  = i_align_cycles;
        end
      end
      ST_ALIGN: begin
        if (stop_req) begin
          state_n  = ST_BRAKE;
          tmr_load = 1'b1;
          tmr_val  = i_brake_cycles;
        end else if (tmr_tc) begin
          state_n  = ST_RAMP;
          tmr_load = 1'b1;
          tmr_val  = ramp_start;
          period_n = ramp_start;
          sub_n    = '0;
        end
      end
      ST_RAMP: begin
        if (stop_req) begin
          state_n  = ST_BRAKE;
          tmr_load = 1'b1;
          tmr_val  = i_brake_cycles;
        end else if (tmr_tc) begin
          trig_n   = 1'b1;
          tmr_load = 1'b1;
          if (sub_cnt == SUB_LAST) begin
            sub_n    = '0;
            period_n = period_next;
            tmr_val  = period_next;
            if (period_next == i_run_period) state_n = ST_RUN;
          end else begin
            sub_n   = sub_cnt + PW'(1);
            tmr_val = cur_period;
          end
        end
      end
      ST_RUN: begin
        if (stop_req) begin
          state_n  = ST_BRAKE;
          tmr_load = 1'b1;
          tmr_val  = i_brake_cycles;
        end else if (tmr_tc) begin
          trig_n   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = i_run_period;
        end
      end
      ST_BRAKE: begin
        if (tmr_tc) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state                <= ST_IDLE;
      sub_cnt              <= '0;
      cur_period           <= '0;
      o_step_trigger       <= 1'b0;
      o_force_step_trigger <= 1'b0;
      o_force_step_value   <= 3'd0;
      o_step_reverse       <= 1'b0;
      o_brake              <= 1'b0;
      o_power              <= '0;
      o_state              <= ST_IDLE;
      o_running            <= 1'b0;
    end else begin
      state                <= state_n;
      sub_cnt              <= sub_n;
      cur_period           <= period_n;
      o_step_trigger       <= trig_n;
      o_force_step_trigger <= (state == ST_IDLE) && (state_n == ST_ALIGN);
      if ((state == ST_IDLE) && (state_n == ST_ALIGN)) begin
        o_step_reverse     <= i_dir;
        o_force_step_value <= sanitize_step(i_align_step);
      end
      o_brake   <= (state_n == ST_BRAKE);
      o_running <= (state_n == ST_RUN);
      o_state   <= state_n;
      case (state_n)
        ST_ALIGN:       o_power <= i_align_power;
        ST_RAMP, ST_RUN: o_power <= i_run_power;
        default:        o_power <= '0;
      endcase
    end
  end

  assign o_force_substep = '0;

endmodule

// File: tb/tb_commutation_sequencer.sv
// Directed bench for commutation_sequencer: start-up, ramp profile, brake, edges, reset.
module tb_commutation_sequencer;

  localparam int K_NSUBSTEPS = 10;
  localparam int K_PERIOD_W  = 16;
  localparam int PW          = $clog2(K_NSUBSTEPS);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  enable, brake_req, dir;
  logic [2:0]            align_step;
  logic [K_PERIOD_W-1:0] align_cycles, start_period, run_period, ramp_dec, brake_cycles;
  logic [PW-1:0]         align_power, run_power;
  logic                  step_trigger, force_step_trigger, step_reverse, brake, running;
  logic [2:0]            force_step_value, state;
  logic [PW-1:0]         force_substep, power;

  int n_checks = 0;
  int n_fail   = 0;
  int trig_t[32];
  int trig_s[32];

  always #5 clk = ~clk;

  commutation_sequencer #(.K_NSUBSTEPS(K_NSUBSTEPS), .K_PERIOD_W(K_PERIOD_W)) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_enable             (enable),
    .i_brake_req          (brake_req),
    .i_dir                (dir),
    .i_align_step         (align_step),
    .i_align_cycles       (align_cycles),
    .i_align_power        (align_power),
    .i_run_power          (run_power),
    .i_start_period       (start_period),
    .i_run_period         (run_period),
    .i_ramp_dec           (ramp_dec),
    .i_brake_cycles       (brake_cycles),
    .o_step_trigger       (step_trigger),
    .o_force_step_trigger (force_step_trigger),
    .o_force_step_value   (force_step_value),
    .o_force_substep      (force_substep),
    .o_step_reverse       (step_reverse),
    .o_brake              (brake),
    .o_power              (power),
    .o_state              (state),
    .o_running            (running)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records cycle offsets (relative to the current cycle) of the next n triggers.
  task automatic measure(input int n, input int budget);
    int t;
    int k;
    t = 0;
    k = 0;
    while (k < n && t < budget) begin
      tick();
      t++;
      if (step_trigger) begin
        trig_t[k] = t;
        trig_s[k] = int'(state);
        k++;
      end
    end
    check("trig_count", k, n);
  endtask

  task automatic pulse_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    tick();
    rst_n  = 1'b1;
  endtask

  initial begin
    int n;
    int bad;
    rst_n = 1'b0; enable = 1'b0; brake_req = 1'b0; dir = 1'b1;
    align_step = 3'd2; align_cycles = 16'd5; align_power = 4'd3; run_power = 4'd5;
    start_period = 16'd8; run_period = 16'd4; ramp_dec = 16'd2; brake_cycles = 16'd3;
    tick();
    tick();
    check("rst_state", state, 3'd0);
    check("rst_outputs", {step_trigger, force_step_trigger, force_step_value, force_substep,
                          step_reverse, brake, power, running}, 0);
    rst_n = 1'b1;
    tick();
    check("idle_hold", state, 3'd0);

    // Basic start
    enable = 1'b1;
    tick();
    check("align_state", state, 3'd1);
    check("force_pulse", force_step_trigger, 1'b1);
    check("force_value", force_step_value, 3'd2);
    check("reverse_latch", step_reverse, 1'b1);
    check("align_power", power, 4'd3);
    n = 0;
    bad = 0;
    while (state != 3'd2 && n < 50) begin
      tick();
      n++;
      if (n == 1 && force_step_trigger) bad++;
      if (step_trigger) bad++;
    end
    check("align_len", n, 5);
    check("align_quiet", bad, 0);
    check("ramp_power", power, 4'd5);

    // Ramp profile 8 -> 6 -> 4
    measure(23, 400);
    check("ramp_first", trig_t[0], 8);
    check("ramp_t9", trig_t[9], 80);
    check("ramp_t10", trig_t[10], 86);
    check("ramp_state18", trig_s[18], 3'd2);
    check("ramp_t19", trig_t[19], 140);
    check("run_state19", trig_s[19], 3'd3);
    check("run_t20", trig_t[20], 144);
    check("run_t22", trig_t[22], 152);
    check("running", running, 1'b1);

    // Direction stays latched during RUN
    dir = 1'b0;
    repeat (5) tick();
    check("dir_latched", step_reverse, 1'b1);

    // Brake
    brake_req = 1'b1;
    tick();
    check("brake_state", state, 3'd4);
    check("brake_power", power, 4'd0);
    check("brake_no_trig", step_trigger, 1'b0);
    n = 0;
    bad = 0;
    while (brake === 1'b1 && n < 20) begin
      n++;
      tick();
      if (step_trigger) bad++;
    end
    check("brake_len", n, 3);
    check("brake_to_idle", state, 3'd0);
    repeat (10) begin
      tick();
      if (step_trigger || state != 3'd0) bad++;
    end
    check("idle_after_brake", bad, 0);

    // Edge values: step 7, zero align and zero periods
    brake_req = 1'b0; align_step = 3'd7; align_cycles = 16'd0;
    start_period = 16'd0; run_period = 16'd0; ramp_dec = 16'd0;
    tick();
    check("edge_align", state, 3'd1);
    check("step7_value", force_step_value, 3'd0);
    check("dir_relatch", step_reverse, 1'b0);
    tick();
    check("align0_len", state, 3'd2);
    measure(10, 20);
    check("p0_first", trig_t[0], 1);
    check("p0_t9", trig_t[9], 10);
    check("p0_run", trig_s[9], 3'd3);

    // Clamp: 6 - 5 would be 1, clamps to run period 4
    pulse_reset();
    start_period = 16'd6; run_period = 16'd4; ramp_dec = 16'd5;
    align_cycles = 16'd2; align_step = 3'd4; enable = 1'b1;
    tick();
    check("clamp_force", force_step_value, 3'd4);
    tick();
    tick();
    check("clamp_ramp", state, 3'd2);
    measure(11, 100);
    check("clamp_first", trig_t[0], 6);
    check("clamp_t9", trig_t[9], 60);
    check("clamp_run", trig_s[9], 3'd3);
    check("clamp_t10", trig_t[10], 64);

    // Reset mid-RAMP
    pulse_reset();
    start_period = 16'd20; ramp_dec = 16'd1; align_cycles = 16'd1; dir = 1'b1; enable = 1'b1;
    tick();
    tick();
    check("pre_rst_ramp", state, 3'd2);
    check("pre_rst_rev", step_reverse, 1'b1);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_state", state, 3'd0);
    check("mid_rst_outputs", {step_trigger, force_step_trigger, force_step_value, force_substep,
                              step_reverse, brake, power, running}, 0);
    rst_n = 1'b1;
    enable = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
